// File: rtl/config_pkg.sv
// rtl/config_pkg.sv - shared widths, micro-instruction format and scoreboard types
package config_pkg;

    localparam int AW = 4;
    localparam int CW = 8;

    typedef logic [AW-1:0]     addr_t;
    typedef logic [2**AW-1:0]  sboard_t;

    // vrs1/vrs2 are sources, vrs3 is the destination
    typedef struct packed {
        logic [CW-1:0] op;
        addr_t         vrs3;
        addr_t         vrs2;
        addr_t         vrs1;
    } uinstr_t;

    parameter int MAX_OUT_DEF = 8;

    // One-hot mask selecting a single register's busy bit
    function automatic sboard_t addr_mask(input addr_t a);
        return sboard_t'(1) << a;
    endfunction

endpackage

// File: rtl/uinstr_issue_ctrl_scoreboard.sv
// rtl/uinstr_issue_ctrl_scoreboard.sv - per-register pending-write bits with set-over-clear priority
module uinstr_scoreboard
    import config_pkg::*;
(
    input  logic    clk_i,
    input  logic    arst_i,
    input  logic    set_en,
    input  addr_t   set_addr,
    input  logic    clr_en,
    input  addr_t   clr_addr,
    output sboard_t busy
);

    sboard_t set_mask;
    sboard_t clr_mask;

    // Decode set/clear requests into masks
    always_comb begin
        set_mask = set_en ? addr_mask(set_addr) : '0;
        clr_mask = clr_en ? addr_mask(clr_addr) : '0;
    end

    // Clear first, then set, so a same-cycle set on the same register wins
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            busy <= '0;
        end else begin
            busy <= (busy & ~clr_mask) | set_mask;
        end
    end

endmodule

// File: rtl/uinstr_issue_ctrl.sv
// rtl/uinstr_issue_ctrl.sv - in-order uinstr issue with hazard scoreboard and in-flight cap (option: UINSTR_ISSUE_CPL_BYPASS_EN)
module uinstr_issue_ctrl
    import config_pkg::*;
#(
    parameter int MAX_OUT = MAX_OUT_DEF
) (
    input  logic                         clk_i,
    input  logic                         arst_i,
    input  uinstr_t                      in_uinstr_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    output uinstr_t                      iss_uinstr_o,
    output logic                         iss_valid_o,
    input  logic                         iss_ready_i,
    input  logic                         cpl_valid_i,
    input  addr_t                        cpl_addr_i,
    output sboard_t                      busy_o,
    output logic [$clog2(MAX_OUT+1)-1:0] out_cnt_o,
    output logic                         idle_o
);

    localparam int CNTW = $clog2(MAX_OUT + 1);
    localparam logic [CNTW-1:0] MAX_CNT = CNTW'(MAX_OUT);

    logic            hold_v;
    uinstr_t         hold_q;
    logic [CNTW-1:0] cnt_q;
    logic [CNTW-1:0] cnt_lim;
    sboard_t         busy;
    sboard_t         busy_eff;
    logic            hazard;
    logic            iss_fire;
    logic            in_fire;
    logic            cpl_dec;

    // A completion only decrements when something is outstanding (saturate at 0)
    assign cpl_dec  = cpl_valid_i && (cnt_q != '0);
    assign iss_fire = iss_valid_o && iss_ready_i;
    assign in_fire  = in_valid_i && in_ready_o;

    // Hazard/limit view: registered state, or with a same-cycle completion folded in
    always_comb begin
`ifdef UINSTR_ISSUE_CPL_BYPASS_EN
        busy_eff = busy & ~(cpl_valid_i ? addr_mask(cpl_addr_i) : sboard_t'(0));
        cnt_lim  = cnt_q - CNTW'(cpl_dec);
`else
        busy_eff = busy;
        cnt_lim  = cnt_q;
`endif
        hazard = busy_eff[hold_q.vrs1] | busy_eff[hold_q.vrs2] | busy_eff[hold_q.vrs3];
    end

    // Issue and accept handshakes; a held uinstr leaving frees the slot the same cycle
    always_comb begin
        iss_valid_o  = hold_v && !hazard && (cnt_lim < MAX_CNT);
        in_ready_o   = !hold_v || iss_fire;
        iss_uinstr_o = hold_q;
        out_cnt_o    = cnt_q;
        busy_o       = busy;
        idle_o       = !hold_v && (cnt_q == '0);
    end

    // Single-entry hold register between the front end and the datapath
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            hold_v <= 1'b0;
            hold_q <= '0;
        end else if (in_fire) begin
            hold_v <= 1'b1;
            hold_q <= in_uinstr_i;
        end else if (iss_fire) begin
            hold_v <= 1'b0;
        end
    end

    // In-flight counter; simultaneous issue and completion cancel out
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            cnt_q <= '0;
        end else if (iss_fire && !cpl_dec) begin
            cnt_q <= cnt_q + CNTW'(1);
        end else if (!iss_fire && cpl_dec) begin
            cnt_q <= cnt_q - CNTW'(1);
        end
    end

    uinstr_scoreboard u_sboard (
        .clk_i    (clk_i),
        .arst_i   (arst_i),
        .set_en   (iss_fire),
        .set_addr (hold_q.vrs3),
        .clr_en   (cpl_valid_i),
        .clr_addr (cpl_addr_i),
        .busy     (busy)
    );

`ifndef SYNTHESIS
    // A completion must match an outstanding write to that register
    cpl_protocol_a: assert property (@(posedge clk_i) disable iff (arst_i)
        cpl_valid_i |-> ((cnt_q != '0) && busy[cpl_addr_i]))
        else $error("uinstr_issue_ctrl: completion without matching outstanding write");
`endif

endmodule
